// File: rtl/aes_pkg.sv
// Shared types, constants and byte-substitution helpers for the AES-128 cipher controller.
package aes_pkg;

  localparam int unsigned N      = 128;
  localparam int unsigned R      = 10;
  localparam int unsigned RoundW = $clog2(R + 1);

  typedef enum logic [1:0] {StIdle, StRound, StDone} state_e;

  localparam logic [7:0] SBOX [256] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  localparam logic [7:0] RCON [1:10] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80, 8'h1b, 8'h36
  };

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
  endfunction

endpackage

// File: rtl/aes_key_step.sv
// One AES-128 key-expansion step: derives the next round key from the current one.
module aes_key_step
  import aes_pkg::*;
(
  input  logic [127:0] key_in,
  input  logic [7:0]   rcon,
  output logic [127:0] key_out
);

  logic [31:0] w0, w1, w2, w3, w4, w5, w6, w7;

  always_comb begin
    w0      = key_in[127:96];
    w1      = key_in[95:64];
    w2      = key_in[63:32];
    w3      = key_in[31:0];
    w4      = w0 ^ sub_word(rot_word(w3)) ^ {rcon, 24'h000000};
    w5      = w1 ^ w4;
    w6      = w2 ^ w5;
    w7      = w3 ^ w6;
    key_out = {w4, w5, w6, w7};
  end

endmodule

// File: rtl/aes_cipher_ctrl.sv
// Sequencing controller for an iterative AES-128 round datapath: accepts a block,
// steps rounds 0..R with on-the-fly round keys, then holds the result until taken.
module aes_cipher_ctrl
  import aes_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N-1:0]      plain_text,
  input  logic [N-1:0]      cipher_key,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N-1:0]      cipher_text,
  output logic              busy,
  output logic              dp_en,
  output logic              dp_first,
  output logic              dp_last,
  output logic [RoundW-1:0] dp_roundnum,
  output logic [N-1:0]      dp_state_in,
  output logic [N-1:0]      dp_round_key,
  input  logic [N-1:0]      dp_state_out
);

  localparam logic [RoundW-1:0] LastRound = RoundW'(R);

  state_e            state_q, state_d;
  logic [RoundW-1:0] round_q, round_d;
  logic [N-1:0]      key_q, key_d;
  logic [N-1:0]      text_q, text_d;
  logic [N-1:0]      key_next;
  logic [7:0]        rcon;

  // The step taken in the last round is never used, so feed it a zero rcon.
  always_comb begin
    rcon = 8'h00;
    if (round_q < LastRound) begin
      rcon = RCON[round_q + 1'b1];
    end
  end

  aes_key_step u_key_step (
    .key_in  (key_q),
    .rcon    (rcon),
    .key_out (key_next)
  );

  always_comb begin
    state_d = state_q;
    round_d = round_q;
    key_d   = key_q;
    text_d  = text_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid) begin
          text_d  = plain_text;
          key_d   = cipher_key;
          round_d = '0;
          state_d = StRound;
        end
      end
      StRound: begin
        key_d = key_next;
        if (round_q == LastRound) begin
          state_d = StDone;
        end else begin
          round_d = round_q + 1'b1;
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      round_q <= '0;
      key_q   <= '0;
      text_q  <= '0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      key_q   <= key_d;
      text_q  <= text_d;
    end
  end

  // Data outputs are forced to zero whenever their qualifier is low.
  always_comb begin
    in_ready     = (state_q == StIdle);
    busy         = (state_q != StIdle);
    dp_en        = (state_q == StRound);
    out_valid    = (state_q == StDone);
    dp_first     = dp_en && (round_q == '0);
    dp_last      = dp_en && (round_q == LastRound);
    dp_roundnum  = dp_en ? round_q : '0;
    dp_state_in  = dp_en ? text_q : '0;
    dp_round_key = dp_en ? key_q : '0;
    cipher_text  = out_valid ? dp_state_out : '0;
  end

endmodule

// File: tb/tb_aes_cipher_ctrl.sv
// Bench for aes_cipher_ctrl: a behavioural round datapath on the dp_* ports and a
// full AES-128 reference model provide the expected round keys and ciphertexts.
module tb_aes_cipher_ctrl;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         out_ready = 1'b0;
  logic [127:0] plain_text = '0;
  logic [127:0] cipher_key = '0;
  logic [127:0] dp_state_out = '0;
  logic         in_ready, out_valid, busy, dp_en, dp_first, dp_last;
  logic [3:0]   dp_roundnum;
  logic [127:0] cipher_text, dp_state_in, dp_round_key;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_n = 0;
  int last_acc = 0;
  int prev_acc = 0;
  int ov_n = 0;

  logic [7:0] sbox_t [256];

  localparam logic [127:0] FipsKey = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] FipsPt  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] FipsCt  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  always #5 clk = ~clk;

  aes_cipher_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .plain_text   (plain_text),
    .cipher_key   (cipher_key),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .cipher_text  (cipher_text),
    .busy         (busy),
    .dp_en        (dp_en),
    .dp_first     (dp_first),
    .dp_last      (dp_last),
    .dp_roundnum  (dp_roundnum),
    .dp_state_in  (dp_state_in),
    .dp_round_key (dp_round_key),
    .dp_state_out (dp_state_out)
  );

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ a;
      a = a[7] ? ({a[6:0], 1'b0} ^ 8'h1b) : {a[6:0], 1'b0};
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(input logic [7:0] x, input int n);
    logic [15:0] d = {x, x};
    return d[15-n -: 8];
  endfunction

  // S-box derived from first principles: GF(2^8) inverse followed by the affine map.
  task automatic build_sbox;
    logic [7:0] inv;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      sbox_t[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [127:0] aes_round(input logic [127:0] s, input logic [127:0] k,
                                             input logic last);
    logic [7:0]   b [16];
    logic [7:0]   o [16];
    logic [7:0]   a0, a1, a2, a3;
    logic [127:0] r;
    for (int i = 0; i < 16; i++) b[i] = sbox_t[s[127-8*i -: 8]];
    for (int c = 0; c < 4; c++)
      for (int rw = 0; rw < 4; rw++) o[4*c+rw] = b[4*((c+rw)%4)+rw];
    if (!last) begin
      for (int c = 0; c < 4; c++) begin
        a0 = o[4*c]; a1 = o[4*c+1]; a2 = o[4*c+2]; a3 = o[4*c+3];
        o[4*c]   = gmul(8'h02, a0) ^ gmul(8'h03, a1) ^ a2 ^ a3;
        o[4*c+1] = a0 ^ gmul(8'h02, a1) ^ gmul(8'h03, a2) ^ a3;
        o[4*c+2] = a0 ^ a1 ^ gmul(8'h02, a2) ^ gmul(8'h03, a3);
        o[4*c+3] = gmul(8'h03, a0) ^ a1 ^ a2 ^ gmul(8'h02, a3);
      end
    end
    for (int i = 0; i < 16; i++) r[127-8*i -: 8] = o[i];
    return r ^ k;
  endfunction

  function automatic logic [127:0] round_key(input logic [127:0] key, input int n);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
        t = t ^ {rc, 24'h000000};
        rc = gmul(rc, 8'h02);
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*n], w[4*n+1], w[4*n+2], w[4*n+3]};
  endfunction

  function automatic logic [127:0] aes_ref(input logic [127:0] key, input logic [127:0] pt);
    logic [127:0] s = pt ^ round_key(key, 0);
    for (int r = 1; r <= 10; r++) s = aes_round(s, round_key(key, r), r == 10);
    return s;
  endfunction

  // Behavioural round datapath driven by the controller.
  always @(posedge clk) begin
    if (dp_en) begin
      dp_state_out <= dp_first ? (dp_state_in ^ dp_round_key)
                               : aes_round(dp_state_out, dp_round_key, dp_last);
    end
  end

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst && in_valid && in_ready) begin
      acc_n    <= acc_n + 1;
      last_acc <= cyc;
      prev_acc <= last_acc;
    end
  end

  always @(negedge clk) if (out_valid) ov_n <= ov_n + 1;

  task automatic tick;
    @(negedge clk);
  endtask

  task automatic send_block(input logic [127:0] k, input logic [127:0] p);
    int n = 0;
    plain_text = p;
    cipher_key = k;
    in_valid   = 1'b1;
    while (!in_ready && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL accept_timeout in_ready=%b required 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    int n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    lat = cyc - 1 - last_acc;
    checks++;
    if (out_valid !== 1'b1) begin
      errors++;
      $display("FAIL out_valid_timeout out_valid=%b required 1", out_valid);
    end
  endtask

  task automatic take_out;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_reset;
    rst        = 1'b1;
    in_valid   = 1'b1;
    plain_text = {$urandom, $urandom, $urandom, $urandom};
    cipher_key = {$urandom, $urandom, $urandom, $urandom};
    repeat (3) begin
      tick();
      checks++;
      if ({in_ready, out_valid, busy, dp_en, dp_first, dp_last} !== 6'b100000 ||
          {dp_roundnum, dp_state_in, dp_round_key, cipher_text} !== '0 || acc_n !== 0) begin
        errors++;
        $display("FAIL reset_outputs flags=%b%b%b%b%b%b rn=%0d acc=%0d required 100000 0 0",
                 in_ready, out_valid, busy, dp_en, dp_first, dp_last, dp_roundnum, acc_n);
      end
    end
    rst      = 1'b0;
    in_valid = 1'b0;
    tick();
    checks++;
    if (in_ready !== 1'b1 || busy !== 1'b0 || acc_n !== 0) begin
      errors++;
      $display("FAIL reset_release in_ready=%b busy=%b acc=%0d required 1 0 0",
               in_ready, busy, acc_n);
    end
  endtask

  task automatic test_key_seq;
    logic [127:0] k = 128'h0f1571c947d9e8590cb7add6af7f6798;
    logic [127:0] p = {$urandom, $urandom, $urandom, $urandom};
    logic [127:0] want;
    send_block(k, p);
    for (int r = 0; r <= 10; r++) begin
      checks++;
      if (dp_en !== 1'b1 || dp_roundnum !== 4'(r) || dp_first !== (r == 0) ||
          dp_last !== (r == 10) || dp_state_in !== p) begin
        errors++;
        $display("FAIL round_ctrl r=%0d en=%b rn=%0d first=%b last=%b", r, dp_en, dp_roundnum,
                 dp_first, dp_last);
      end
      checks++;
      if (dp_round_key !== round_key(k, r)) begin
        errors++;
        $display("FAIL round_key r=%0d got %h required %h", r, dp_round_key, round_key(k, r));
      end
      want = (r == 1) ? 128'hdc9037b09b49dfe997fe723f388115a7 :
             (r == 2) ? 128'hd2c96bb74980b45ede7ec661e6ffd3c6 :
                        128'hb48ef352ba98134e7f4d592086261876;
      if (r == 1 || r == 2 || r == 10) begin
        checks++;
        if (dp_round_key !== want) begin
          errors++;
          $display("FAIL round_key_vec r=%0d got %h required %h", r, dp_round_key, want);
        end
      end
      tick();
    end
    checks++;
    if (out_valid !== 1'b1 || cipher_text !== aes_ref(k, p) || dp_en !== 1'b0) begin
      errors++;
      $display("FAIL keyseq_done out_valid=%b ct=%h required 1 %h", out_valid, cipher_text,
               aes_ref(k, p));
    end
    take_out();
  endtask

  task automatic test_fips;
    int lat;
    send_block(FipsKey, FipsPt);
    wait_out(lat);
    checks++;
    if (lat !== 11) begin
      errors++;
      $display("FAIL fips_latency got %0d required 11", lat);
    end
    checks++;
    if (cipher_text !== FipsCt) begin
      errors++;
      $display("FAIL fips_ct got %h required %h", cipher_text, FipsCt);
    end
    take_out();
  endtask

  task automatic test_backpressure;
    logic [127:0] k1 = {$urandom, $urandom, $urandom, $urandom};
    logic [127:0] p1 = {$urandom, $urandom, $urandom, $urandom};
    logic [127:0] k2 = {$urandom, $urandom, $urandom, $urandom};
    logic [127:0] p2 = {$urandom, $urandom, $urandom, $urandom};
    logic [127:0] ct0;
    int lat, a0;
    send_block(k1, p1);
    wait_out(lat);
    ct0        = cipher_text;
    a0         = acc_n;
    plain_text = p2;
    cipher_key = k2;
    in_valid   = 1'b1;
    checks++;
    if (ct0 !== aes_ref(k1, p1)) begin
      errors++;
      $display("FAIL bp_ct got %h required %h", ct0, aes_ref(k1, p1));
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (out_valid !== 1'b1 || cipher_text !== ct0 || in_ready !== 1'b0 || acc_n !== a0) begin
        errors++;
        $display("FAIL bp_hold i=%0d out_valid=%b in_ready=%b acc=%0d ct=%h required 1 0 %0d %h",
                 i, out_valid, in_ready, acc_n, cipher_text, a0, ct0);
      end
    end
    take_out();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL bp_release in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
    end
    tick();
    in_valid = 1'b0;
    checks++;
    if (acc_n !== a0 + 1 || last_acc - prev_acc !== 18) begin
      errors++;
      $display("FAIL bp_next_accept acc=%0d spacing=%0d required %0d 18", acc_n,
               last_acc - prev_acc, a0 + 1);
    end
    wait_out(lat);
    checks++;
    if (cipher_text !== aes_ref(k2, p2)) begin
      errors++;
      $display("FAIL bp_ct2 got %h required %h", cipher_text, aes_ref(k2, p2));
    end
    take_out();
  endtask

  task automatic test_reset_mid;
    int n = 0;
    int ov0, lat;
    send_block(FipsKey, FipsPt);
    while (!(dp_en && dp_roundnum == 4'd5) && n < 20) begin
      tick();
      n++;
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({in_ready, out_valid, busy, dp_en, dp_first, dp_last} !== 6'b100000 ||
        {dp_roundnum, dp_state_in, dp_round_key} !== '0) begin
      errors++;
      $display("FAIL midreset_outputs flags=%b%b%b%b%b%b rn=%0d required 100000 0",
               in_ready, out_valid, busy, dp_en, dp_first, dp_last, dp_roundnum);
    end
    rst = 1'b0;
    ov0 = ov_n;
    repeat (15) tick();
    checks++;
    if (ov_n !== ov0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL midreset_no_output ov=%0d in_ready=%b required %0d 1", ov_n, in_ready, ov0);
    end
    send_block(FipsKey, FipsPt);
    wait_out(lat);
    checks++;
    if (cipher_text !== FipsCt || lat !== 11) begin
      errors++;
      $display("FAIL midreset_recover ct=%h lat=%0d required %h 11", cipher_text, lat, FipsCt);
    end
    take_out();
  endtask

  task automatic test_back_to_back;
    logic [127:0] k1 = {$urandom, $urandom, $urandom, $urandom};
    logic [127:0] p1 = {$urandom, $urandom, $urandom, $urandom};
    logic [127:0] k2 = {$urandom, $urandom, $urandom, $urandom};
    logic [127:0] p2 = {$urandom, $urandom, $urandom, $urandom};
    int a0 = acc_n;
    int n = 0;
    plain_text = p1;
    cipher_key = k1;
    in_valid   = 1'b1;
    out_ready  = 1'b1;
    while (acc_n != a0 + 1 && n < 40) begin
      tick();
      n++;
    end
    plain_text = p2;
    cipher_key = k2;
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (out_valid !== 1'b1 || cipher_text !== aes_ref(k1, p1)) begin
      errors++;
      $display("FAIL b2b_ct1 got %h required %h", cipher_text, aes_ref(k1, p1));
    end
    n = 0;
    while (acc_n < a0 + 2 && n < 40) begin
      tick();
      n++;
    end
    in_valid = 1'b0;
    checks++;
    if (acc_n !== a0 + 2 || last_acc - prev_acc !== 13) begin
      errors++;
      $display("FAIL b2b_spacing acc=%0d spacing=%0d required %0d 13", acc_n,
               last_acc - prev_acc, a0 + 2);
    end
    n = 0;
    while (!out_valid && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (out_valid !== 1'b1 || cipher_text !== aes_ref(k2, p2)) begin
      errors++;
      $display("FAIL b2b_ct2 got %h required %h", cipher_text, aes_ref(k2, p2));
    end
    tick();
    out_ready = 1'b0;
  endtask

  task automatic test_random;
    logic [127:0] k, p, want;
    int lat, stall;
    for (int it = 0; it < 6; it++) begin
      k     = {$urandom, $urandom, $urandom, $urandom};
      p     = {$urandom, $urandom, $urandom, $urandom};
      want  = aes_ref(k, p);
      stall = $urandom_range(0, 3);
      send_block(k, p);
      wait_out(lat);
      checks++;
      if (cipher_text !== want || lat !== 11) begin
        errors++;
        $display("FAIL rand_ct it=%0d got %h lat=%0d required %h 11", it, cipher_text, lat, want);
      end
      repeat (stall) begin
        tick();
        checks++;
        if (out_valid !== 1'b1 || cipher_text !== want) begin
          errors++;
          $display("FAIL rand_hold it=%0d out_valid=%b ct=%h required 1 %h", it, out_valid,
                   cipher_text, want);
        end
      end
      take_out();
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    build_sbox();
    test_reset();
    test_key_seq();
    test_fips();
    test_backpressure();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
